// File: rtl/bcd_999_ctrl_if.sv
// Command/status bundle between a host and the three-digit BCD counter controller.
interface bcd_999_ctrl_if #(
  parameter int unsigned WIDTH = 5
);
  logic             start;
  logic             pause;
  logic             clear;
  logic [WIDTH-1:0] target_2;
  logic [WIDTH-1:0] target_1;
  logic [WIDTH-1:0] target_0;
  logic             enb;
  logic             cnt_clr;
  logic [WIDTH-1:0] d_2;
  logic [WIDTH-1:0] d_1;
  logic [WIDTH-1:0] d_0;
  logic [1:0]       state;
  logic             running;
  logic             done;

  modport master (
    output start, pause, clear, target_2, target_1, target_0,
    input  enb, cnt_clr, d_2, d_1, d_0, state, running, done
  );

  modport slave (
    input  start, pause, clear, target_2, target_1, target_0,
    output enb, cnt_clr, d_2, d_1, d_0, state, running, done
  );
endinterface

// File: rtl/bcd_999_ctrl.sv
// Run/pause/clear controller for an external 000..999 BCD counter.
// It issues prescaled count enables and keeps a shadow copy of the count.
module bcd_999_ctrl #(
  parameter int unsigned WIDTH    = 5,
  parameter int unsigned TICK_DIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  bcd_999_ctrl_if.slave    bus
);
  localparam int unsigned PW = 10;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [WIDTH-1:0] NINE = WIDTH'(9);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [WIDTH-1:0] d2_q, d2_d, d1_q, d1_d, d0_q, d0_d;
  logic             enb_q, enb_d;
  logic             cnt_clr_q, cnt_clr_d;

  logic [WIDTH-1:0] inc2, inc1, inc0;
  logic             tgt_eq_cur, tgt_eq_inc;
  logic             advance;

  always_comb begin
    inc0 = (d0_q == NINE) ? '0 : d0_q + 1'b1;
    inc1 = d1_q;
    inc2 = d2_q;
    if (d0_q == NINE) begin
      inc1 = (d1_q == NINE) ? '0 : d1_q + 1'b1;
      if (d1_q == NINE) begin
        inc2 = (d2_q == NINE) ? '0 : d2_q + 1'b1;
      end
    end
  end

  // Shadow digits never exceed 9, so a target digit above 9 can never match.
  assign tgt_eq_cur = (bus.target_2 == d2_q) && (bus.target_1 == d1_q) &&
                      (bus.target_0 == d0_q);
  assign tgt_eq_inc = (bus.target_2 == inc2) && (bus.target_1 == inc1) &&
                      (bus.target_0 == inc0);

  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    d2_d      = d2_q;
    d1_d      = d1_q;
    d0_d      = d0_q;
    enb_d     = 1'b0;
    cnt_clr_d = 1'b0;
    advance   = 1'b0;

    if (bus.clear) begin
      state_d   = IDLE;
      cnt_clr_d = 1'b1;
      presc_d   = '0;
      d2_d      = '0;
      d1_d      = '0;
      d0_d      = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start && !bus.pause) begin
            state_d = tgt_eq_cur ? DONE : RUN;
            presc_d = '0;
          end
        end
        RUN: begin
          if (bus.pause) begin
            state_d = PAUSE;
          end else begin
            advance = 1'b1;
          end
        end
        PAUSE: begin
          // The resume edge is itself a counting cycle for the prescaler.
          if (bus.start && !bus.pause) begin
            state_d = RUN;
            advance = 1'b1;
          end
        end
        DONE: begin
        end
        default: state_d = IDLE;
      endcase

      if (advance) begin
        if (presc_q == PRESC_LAST) begin
          presc_d = '0;
          enb_d   = 1'b1;
          d2_d    = inc2;
          d1_d    = inc1;
          d0_d    = inc0;
          if (tgt_eq_inc) begin
            state_d = DONE;
          end
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      presc_q   <= '0;
      d2_q      <= '0;
      d1_q      <= '0;
      d0_q      <= '0;
      enb_q     <= 1'b0;
      cnt_clr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      d2_q      <= d2_d;
      d1_q      <= d1_d;
      d0_q      <= d0_d;
      enb_q     <= enb_d;
      cnt_clr_q <= cnt_clr_d;
    end
  end

  assign bus.enb     = enb_q;
  assign bus.cnt_clr = cnt_clr_q;
  assign bus.d_2     = d2_q;
  assign bus.d_1     = d1_q;
  assign bus.d_0     = d0_q;
  assign bus.state   = state_q;
  assign bus.running = (state_q == RUN);
  assign bus.done    = (state_q == DONE);
endmodule
